// File: rtl/i2cread.sv
// ---------------------------------------------------------------------------
// i2cread -- I2C master read sequencer.
// Walks START, slave address, read bit, address ACK, data bytes with
// master ACK/NACK, and STOP. Each step is issued as a command to a
// separate bit layer. Received bytes are written into a destination buffer
// at slots ptr_begin .. ptr_end-1.
// Optional build macro: I2CREAD_TIMEOUT_EN adds a per-command watchdog that
// aborts to STOP (or to WAIT from STOP) after TIMEOUT_CYC waiting cycles.
// ---------------------------------------------------------------------------
module i2cread #(
   parameter int ADDR_SZ     = 7,
   parameter int WORD_SZ     = 8,
   parameter int DATA_SZ     = 4,
   parameter int CMD_SZ      = 3,
   parameter int TIMEOUT_CYC = 255,
   localparam int PTR_W      = $clog2(DATA_SZ) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               init,
   input  logic [ADDR_SZ-1:0] addr,
   input  logic [PTR_W-1:0]   ptr_begin,
   input  logic [PTR_W-1:0]   ptr_end,
   input  logic               cmd_ack,
   input  logic               rx_valid,
   input  logic               rx_bit,
   output logic [CMD_SZ-1:0]  command,
   output logic [WORD_SZ-1:0] data_out,
   output logic [PTR_W-1:0]   ptr_cur,
   output logic               wr_en,
   output logic               ready,
   output logic               nack_err,
   output logic               timeout_err
);

   // Bit-layer command codes
   localparam logic [CMD_SZ-1:0] CMDIDLE  = CMD_SZ'(0);
   localparam logic [CMD_SZ-1:0] CMDSTART = CMD_SZ'(1);
   localparam logic [CMD_SZ-1:0] CMDSTOP  = CMD_SZ'(2);
   localparam logic [CMD_SZ-1:0] CMDBIT0  = CMD_SZ'(3);
   localparam logic [CMD_SZ-1:0] CMDBIT1  = CMD_SZ'(4);
   localparam logic [CMD_SZ-1:0] CMDRBIT  = CMD_SZ'(5);

   // Sequencer states
   localparam logic [2:0] ST_WAIT  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_ADDR  = 3'd2;
   localparam logic [2:0] ST_RW    = 3'd3;
   localparam logic [2:0] ST_AACK  = 3'd4;
   localparam logic [2:0] ST_DATA  = 3'd5;
   localparam logic [2:0] ST_MACK  = 3'd6;
   localparam logic [2:0] ST_STOP  = 3'd7;

   // One bit counter serves both the address and the data phase
   localparam int BCNT_MAX = (ADDR_SZ > WORD_SZ) ? ADDR_SZ : WORD_SZ;
   localparam int BCNT_W   = (BCNT_MAX > 1) ? $clog2(BCNT_MAX) : 1;

   logic [2:0]         r_state;
   logic [ADDR_SZ-1:0] r_addr;
   logic [PTR_W-1:0]   r_ptrBegin;
   logic [PTR_W-1:0]   r_ptrEnd;
   logic [PTR_W-1:0]   r_ptrCur;
   logic [BCNT_W-1:0]  r_bitCnt;
   logic [WORD_SZ-2:0] r_shift;
   logic [WORD_SZ-1:0] r_dataOut;
   logic               r_wrEn;
   logic               r_nack;
   logic               r_tout;

   logic [CMD_SZ-1:0]  w_command;
   logic [PTR_W-1:0]   w_ptrNext;
   logic               w_more;
   logic               w_done;
   logic               w_wdogHit;

   assign w_ptrNext = r_ptrCur + 1'b1;
   assign w_more    = (w_ptrNext < r_ptrEnd);

   // Decode the command presented to the bit layer from the current state
   always_comb begin
      w_command = CMDIDLE;
      case (r_state)
         ST_START: w_command = CMDSTART;
         ST_ADDR:  w_command = r_addr[ADDR_SZ-1] ? CMDBIT1 : CMDBIT0;
         ST_RW:    w_command = CMDBIT1;
         ST_AACK:  w_command = CMDRBIT;
         ST_DATA:  w_command = CMDRBIT;
         ST_MACK:  w_command = w_more ? CMDBIT0 : CMDBIT1;
         ST_STOP:  w_command = CMDSTOP;
         default:  w_command = CMDIDLE;
      endcase
   end

   // Read commands complete on rx_valid, all others on cmd_ack
   assign w_done = (w_command == CMDRBIT) ? rx_valid
                                          : ((w_command != CMDIDLE) && cmd_ack);

`ifdef I2CREAD_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] r_wdog;

   assign w_wdogHit = (r_state != ST_WAIT) && !w_done &&
                      (r_wdog == WD_W'(TIMEOUT_CYC - 1));

   // Count cycles the current command has been waiting; restart per command
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_wdog <= '0;
      else if ((r_state == ST_WAIT) || w_done || w_wdogHit)
         r_wdog <= '0;
      else
         r_wdog <= r_wdog + 1'b1;
   end
`else
   // No watchdog in this build: commands may wait forever
   assign w_wdogHit = (TIMEOUT_CYC < 0);
`endif

   // Main sequencer: advance on the edge that completes the current command
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_WAIT;
         r_addr     <= '0;
         r_ptrBegin <= '0;
         r_ptrEnd   <= '0;
         r_ptrCur   <= '0;
         r_bitCnt   <= '0;
         r_shift    <= '0;
         r_dataOut  <= '0;
         r_wrEn     <= 1'b0;
         r_nack     <= 1'b0;
         r_tout     <= 1'b0;
      end else begin
         r_wrEn <= 1'b0;
         case (r_state)
            ST_WAIT: begin
               if (init) begin
                  r_addr     <= addr;
                  r_ptrBegin <= ptr_begin;
                  r_ptrEnd   <= ptr_end;
                  r_nack     <= 1'b0;
                  r_tout     <= 1'b0;
                  r_state    <= ST_START;
               end
            end
            ST_START: begin
               if (w_done) begin
                  r_bitCnt <= '0;
                  r_state  <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (w_done) begin
                  r_addr <= r_addr << 1;
                  if (r_bitCnt == BCNT_W'(ADDR_SZ - 1)) begin
                     r_bitCnt <= '0;
                     r_state  <= ST_RW;
                  end else begin
                     r_bitCnt <= r_bitCnt + 1'b1;
                  end
               end
            end
            ST_RW: begin
               if (w_done)
                  r_state <= ST_AACK;
            end
            ST_AACK: begin
               if (w_done) begin
                  if (rx_bit) begin
                     r_nack  <= 1'b1;
                     r_state <= ST_STOP;
                  end else begin
                     r_ptrCur <= r_ptrBegin;
                     r_bitCnt <= '0;
                     r_state  <= (r_ptrEnd <= r_ptrBegin) ? ST_STOP : ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_done) begin
                  r_shift <= {r_shift[WORD_SZ-3:0], rx_bit};
                  if (r_bitCnt == BCNT_W'(WORD_SZ - 1)) begin
                     r_dataOut <= {r_shift, rx_bit};
                     r_wrEn    <= 1'b1;
                     r_bitCnt  <= '0;
                     r_state   <= ST_MACK;
                  end else begin
                     r_bitCnt <= r_bitCnt + 1'b1;
                  end
               end
            end
            ST_MACK: begin
               if (w_done) begin
                  r_ptrCur <= w_ptrNext;
                  r_state  <= w_more ? ST_DATA : ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_done)
                  r_state <= ST_WAIT;
            end
            default: r_state <= ST_WAIT;
         endcase

         if (w_wdogHit) begin
            if (r_state == ST_STOP) begin
               r_state <= ST_WAIT;
            end else begin
               r_tout  <= 1'b1;
               r_state <= ST_STOP;
            end
         end
      end
   end

   assign command     = w_command;
   assign data_out    = r_dataOut;
   assign ptr_cur     = r_ptrCur;
   assign wr_en       = r_wrEn;
   assign ready       = (r_state == ST_WAIT);
   assign nack_err    = r_nack;
   assign timeout_err = r_tout;

endmodule

// File: tb/tb_i2cread.sv
// ---------------------------------------------------------------------------
// tb_i2cread -- self-checking bench for i2cread.
// A bit-layer responder answers each command after a random delay while a
// transaction-level model predicts the full command list and buffer writes.
// ---------------------------------------------------------------------------
module tb_i2cread;

   localparam int ADDR_SZ = 7;
   localparam int WORD_SZ = 8;
   localparam int DATA_SZ = 4;
   localparam int CMD_SZ  = 3;
   localparam int PTR_W   = $clog2(DATA_SZ) + 1;
   localparam int TCYC    = 16;

   localparam int C_IDLE  = 0;
   localparam int C_START = 1;
   localparam int C_STOP  = 2;
   localparam int C_BIT0  = 3;
   localparam int C_BIT1  = 4;
   localparam int C_RBIT  = 5;

   logic               clk = 1'b0;
   logic               reset;
   logic               init;
   logic [ADDR_SZ-1:0] addr;
   logic [PTR_W-1:0]   ptr_begin;
   logic [PTR_W-1:0]   ptr_end;
   logic               cmd_ack;
   logic               rx_valid;
   logic               rx_bit;
   logic [CMD_SZ-1:0]  command;
   logic [WORD_SZ-1:0] data_out;
   logic [PTR_W-1:0]   ptr_cur;
   logic               wr_en;
   logic               ready;
   logic               nack_err;
   logic               timeout_err;

   int errors = 0;
   int checks = 0;

   int expCmd[$];
   int expRx[$];
   int expWrPtr[$];
   int expWrData[$];
   logic [7:0] txBytes[4];

   i2cread #(
      .ADDR_SZ(ADDR_SZ), .WORD_SZ(WORD_SZ), .DATA_SZ(DATA_SZ),
      .CMD_SZ(CMD_SZ), .TIMEOUT_CYC(TCYC)
   ) dut (
      .clk(clk), .reset(reset), .init(init), .addr(addr),
      .ptr_begin(ptr_begin), .ptr_end(ptr_end), .cmd_ack(cmd_ack),
      .rx_valid(rx_valid), .rx_bit(rx_bit), .command(command),
      .data_out(data_out), .ptr_cur(ptr_cur), .wr_en(wr_en),
      .ready(ready), .nack_err(nack_err), .timeout_err(timeout_err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Count one comparison and report it if it disagrees
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Every buffer write must match the next predicted (slot, byte) pair
   always @(negedge clk) begin
      if (reset && wr_en) begin
         if (expWrPtr.size() == 0) begin
            checkOutput("wrUnexpected", 32'(wr_en), 32'd0);
         end else begin
            checkOutput("wrPtr", 32'(ptr_cur), 32'(expWrPtr[0]));
            checkOutput("wrData", 32'(data_out), 32'(expWrData[0]));
            void'(expWrPtr.pop_front());
            void'(expWrData.pop_front());
         end
      end
   end

   // Transaction model: predicted command list, slave responses and writes
   task automatic buildModel(input int a, input int pb, input int pe, input int nack);
      expCmd.delete(); expRx.delete(); expWrPtr.delete(); expWrData.delete();
      expCmd.push_back(C_START); expRx.push_back(0);
      for (int i = ADDR_SZ - 1; i >= 0; i--) begin
         expCmd.push_back(((a >> i) & 1) ? C_BIT1 : C_BIT0);
         expRx.push_back(0);
      end
      expCmd.push_back(C_BIT1); expRx.push_back(0);
      expCmd.push_back(C_RBIT); expRx.push_back(nack);
      if (nack == 0 && pe > pb) begin
         for (int p = pb; p < pe; p++) begin
            for (int b = WORD_SZ - 1; b >= 0; b--) begin
               expCmd.push_back(C_RBIT);
               expRx.push_back((txBytes[p - pb] >> b) & 1);
            end
            expWrPtr.push_back(p);
            expWrData.push_back(int'(txBytes[p - pb]));
            expCmd.push_back((p + 1 < pe) ? C_BIT0 : C_BIT1);
            expRx.push_back(0);
         end
      end
      expCmd.push_back(C_STOP); expRx.push_back(0);
   endtask

   // Launch one read and answer its commands; abortIdx < 0 runs to completion
   task automatic applyStimulus(input int a, input int pb, input int pe,
                                input int nack, input int abortIdx);
      buildModel(a, pb, pe, nack);
      @(negedge clk);
      checkOutput("readyIdle", 32'(ready), 32'd1);
      addr = ADDR_SZ'(a); ptr_begin = PTR_W'(pb); ptr_end = PTR_W'(pe); init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      checkOutput("readyBusy", 32'(ready), 32'd0);
      for (int k = 0; k < expCmd.size(); k++) begin
         checkOutput($sformatf("cmd%0d", k), 32'(command), 32'(expCmd[k]));
         if (k == abortIdx) begin
            reset = 1'b0;
            #1;
            checkOutput("rstCmd", 32'(command), C_IDLE);
            checkOutput("rstReady", 32'(ready), 32'd1);
            checkOutput("rstPtr", 32'(ptr_cur), 32'd0);
            checkOutput("rstWr", 32'(wr_en), 32'd0);
            checkOutput("rstData", 32'(data_out), 32'd0);
            expWrPtr.delete(); expWrData.delete();
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         repeat ($urandom_range(0, 3)) begin
            if (expCmd[k] == C_RBIT) cmd_ack = 1'($urandom);
            else rx_valid = 1'($urandom);
            rx_bit = 1'($urandom);
            init = 1'($urandom);
            addr = ADDR_SZ'($urandom);
            @(negedge clk);
            cmd_ack = 1'b0; rx_valid = 1'b0; init = 1'b0;
            checkOutput("cmdHold", 32'(command), 32'(expCmd[k]));
         end
         if (expCmd[k] == C_RBIT) begin
            rx_valid = 1'b1; rx_bit = expRx[k][0];
         end else begin
            cmd_ack = 1'b1;
         end
         @(negedge clk);
         cmd_ack = 1'b0; rx_valid = 1'b0;
      end
      checkOutput("readyEnd", 32'(ready), 32'd1);
      checkOutput("nackErr", 32'(nack_err), 32'(nack));
      checkOutput("toutErr", 32'(timeout_err), 32'd0);
      checkOutput("wrLeft", 32'(expWrPtr.size()), 32'd0);
   endtask

   // Start a read, finish START, then withhold the first address bit's ack
   task automatic watchdogTest();
      buildModel(7'h55, 0, 1, 0);
      @(negedge clk);
      addr = 7'h55; ptr_begin = '0; ptr_end = PTR_W'(1); init = 1'b1;
      @(negedge clk);
      init = 1'b0; cmd_ack = 1'b1;
      @(negedge clk);
      cmd_ack = 1'b0;
`ifdef I2CREAD_TIMEOUT_EN
      repeat (TCYC - 1) @(negedge clk);
      checkOutput("wdBefore", 32'(timeout_err), 32'd0);
      checkOutput("wdCmdBefore", 32'(command), 32'(expCmd[1]));
      @(negedge clk);
      checkOutput("wdTout", 32'(timeout_err), 32'd1);
      checkOutput("wdStop", 32'(command), C_STOP);
      cmd_ack = 1'b1;
      @(negedge clk);
      cmd_ack = 1'b0;
      checkOutput("wdReady", 32'(ready), 32'd1);
      checkOutput("wdToutHeld", 32'(timeout_err), 32'd1);
`else
      repeat (3 * TCYC) @(negedge clk);
      checkOutput("wdStayAddr", 32'(command), 32'(expCmd[1]));
      checkOutput("wdNoTout", 32'(timeout_err), 32'd0);
      checkOutput("wdBusy", 32'(ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
`endif
   endtask

   initial begin
      int pb, pe, nk;
      reset = 1'b0; init = 1'b0; addr = '0; ptr_begin = '0; ptr_end = '0;
      cmd_ack = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0;
      #12;
      checkOutput("resetCmd", 32'(command), C_IDLE);
      checkOutput("resetReady", 32'(ready), 32'd1);
      checkOutput("resetWr", 32'(wr_en), 32'd0);
      checkOutput("resetData", 32'(data_out), 32'd0);
      checkOutput("resetPtr", 32'(ptr_cur), 32'd0);
      checkOutput("resetNack", 32'(nack_err), 32'd0);
      checkOutput("resetTout", 32'(timeout_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Two-byte read from 0x50 into slots 0 and 1
      txBytes[0] = 8'hA5; txBytes[1] = 8'h3C; txBytes[2] = 8'h00; txBytes[3] = 8'h00;
      applyStimulus(7'h50, 0, 2, 0, -1);

      // Address NACK: no writes, nack_err set
      applyStimulus(7'h21, 0, 2, 1, -1);

      // Zero-byte read
      applyStimulus(7'h33, 3, 3, 0, -1);

      // Reset during data bit 4 of the first byte, then a clean read
      txBytes[0] = 8'hC3; txBytes[1] = 8'h5A;
      applyStimulus(7'h2B, 1, 3, 0, 1 + ADDR_SZ + 1 + 1 + 4);
      applyStimulus(7'h2B, 1, 3, 0, -1);

      watchdogTest();

      // Randomized reads
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < 4; i++) txBytes[i] = 8'($urandom);
         pb = $urandom_range(0, DATA_SZ - 1);
         pe = pb + $urandom_range(0, DATA_SZ);
         if ($urandom_range(0, 7) == 0 && pb > 0) pe = pb - 1;
         nk = ($urandom_range(0, 5) == 0) ? 1 : 0;
         applyStimulus(int'($urandom_range(0, 127)), pb, pe, nk, -1);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2cread.md
I2CREAD -- requirements
Module: i2cread

Interface
REQ-001 SHALL have parameter ADDR_SZ, 7, slave address width.
REQ-002 SHALL have parameter WORD_SZ, 8, received byte width.
REQ-003 SHALL have parameter DATA_SZ, 4, destination buffer depth; PTR_W = clog2(DATA_SZ)+1.
REQ-004 SHALL have parameter CMD_SZ, 3, bit-layer command width; codes CMDIDLE/CMDSTART/CMDSTOP/CMDBIT0/CMDBIT1/CMDRBIT from the shared bit-transmit command header.
REQ-005 SHALL have parameter TIMEOUT_CYC, 255, per-command watchdog limit (used only under I2CREAD_TIMEOUT_EN).
REQ-006 clk  input  1  clock, rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-low.
REQ-008 init  input  1  start a read transaction when ready=1.
REQ-009 addr  input  ADDR_SZ  slave address, sampled when init is accepted.
REQ-010 ptr_begin, ptr_end  input  PTR_W each  first buffer slot, one-past-last slot; sampled with init.
REQ-011 cmd_ack  input  1  bit layer accepted current non-read command.
REQ-012 rx_valid, rx_bit  input  1 each  bit layer finished CMDRBIT; sampled SDA value.
REQ-013 command  output  CMD_SZ  command to bit layer.
REQ-014 data_out  output  WORD_SZ  assembled byte.
REQ-015 ptr_cur  output  PTR_W  buffer slot of data_out.
REQ-016 wr_en  output  1  one-cycle write strobe for data_out at ptr_cur.
REQ-017 ready  output  1  idle, init accepted.
REQ-018 nack_err  output  1  address NACKed in last transaction; timeout_err  output  1  watchdog abort.

Function
REQ-019 States SHALL be WAIT, START, ADDR, RW, AACK, DATA, MACK, STOP.
REQ-020 Command handshake: command held constant until completion; completion = cmd_ack for CMDSTART/STOP/BIT0/BIT1, rx_valid for CMDRBIT; state advances on the completing edge.
REQ-021 WAIT: ready=1, command=CMDIDLE; init=1 latches addr/ptrs, clears nack_err/timeout_err, ready=0, -> START. init while busy SHALL be ignored.
REQ-022 START: CMDSTART -> ADDR.
REQ-023 ADDR: ADDR_SZ commands, MSB first, CMDBIT1 for 1, CMDBIT0 for 0, bit counter; after last -> RW.
REQ-024 RW: CMDBIT1 (read) -> AACK.
REQ-025 AACK: CMDRBIT; rx_bit=1 sets nack_err, -> STOP; rx_bit=0 -> DATA, ptr_cur=ptr_begin, or -> STOP if ptr_end<=ptr_begin (zero-byte read).
REQ-026 DATA: WORD_SZ CMDRBIT, rx_bit shifted in MSB first; on last bit data_out valid and wr_en=1 for exactly the following cycle, -> MACK.
REQ-027 MACK: CMDBIT0 (ACK) if ptr_cur+1<ptr_end, else CMDBIT1 (NACK); on completion ptr_cur+1; -> DATA if more bytes, else STOP.
REQ-028 STOP: CMDSTOP -> WAIT; ready=1 the cycle after completion.
REQ-029 ptr_cur SHALL be unsigned PTR_W arithmetic, no wrap; DATA_SZ bytes max per transaction.
REQ-030 rx_valid outside CMDRBIT and cmd_ack during CMDRBIT SHALL be ignored.

Reset
REQ-031 reset=0 SHALL immediately force WAIT, ready=1, command=CMDIDLE, wr_en=0, data_out=0, ptr_cur=0, nack_err=0, timeout_err=0, counters 0, including mid-transaction.

Configuration
REQ-032 Macro I2CREAD_TIMEOUT_EN defined: watchdog counts cycles a command awaits completion; reaching TIMEOUT_CYC sets timeout_err, -> STOP (STOP itself timing out -> WAIT). Undefined: no counter, waits indefinitely, timeout_err tied 0.

Verification
REQ-033 addr=7'h50, ptr 0..2, slave ACKs, bytes 8'hA5,8'h3C -> commands START, 1010000, BIT1, RBIT, 8xRBIT, BIT0, 8xRBIT, BIT1, STOP; wr_en at ptr 0 (A5), 1 (3C); ready=1 at end.
REQ-034 Address NACK (rx_bit=1 in AACK) -> nack_err=1, no wr_en, CMDSTOP, WAIT.
REQ-035 ptr_begin=ptr_end=3 -> after ACK, STOP with zero wr_en.
REQ-036 reset low mid-DATA bit 4 -> same-cycle CMDIDLE, ready=1, ptr_cur=0; next init runs clean.
REQ-037 With I2CREAD_TIMEOUT_EN, TIMEOUT_CYC=16, cmd_ack withheld in ADDR -> timeout_err=1 at cycle 16, CMDSTOP issued; without macro, FSM stays in ADDR.
